// File: rtl/byte_serial_adder.sv
// byte_serial_adder: multi-precision adder that pushes one byte per clock
// through a single 8-bit ripple adder, chaining the carry in a register.
// Optional feature macro: BSA_SUB_EN adds the op_sub port (a - b mode).
//
// Datapath is two stages: p0 registers the selected operand byte pair,
// and the adder stage combines that pair with the carry register. This
// keeps the byte mux out of the carry loop. It also gives a capture-to-result
// latency of NBYTES+1 cycles.

module byteadder (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {8'd0, ci};
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef BSA_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic            c_q, c_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_p0, b_p0;
  logic [KW-1:0]   k_p0;
  logic            vld_p0;

  logic [W-1:0]    b_in;
  logic            c_in;
  logic            capture, fetch, last_p0;
  logic [7:0]      s_byte;
  logic            c_byte, ovf_byte;

`ifdef BSA_SUB_EN
  // Subtract is a + ~b + 1; the stored operand is already the effective one.
  assign b_in = op_sub ? ~b : b;
  assign c_in = op_sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign capture = (state_q == S_IDLE) && in_valid;
  assign last_p0 = (k_p0 == K_LAST);
  // Stop fetching once the top byte pair already sits in p0.
  assign fetch   = (state_q == S_ADD) && !(vld_p0 && last_p0);

  byteadder u_byteadder (
    .x  (a_p0),
    .y  (b_p0),
    .ci (c_q),
    .s  (s_byte),
    .co (c_byte)
  );

  // Signed overflow judged on the top byte against the effective addend.
  assign ovf_byte = (a_p0[7] == b_p0[7]) && (s_byte[7] != a_p0[7]);

  // Next-state decode of the IDLE/ADD/DONE sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)            state_d = S_ADD;
      S_ADD:   if (vld_p0 && last_p0)   state_d = S_DONE;
      S_DONE:  if (out_ready)           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Next values of byte counter, carry chain and result registers.
  always_comb begin
    k_d    = k_q;
    c_d    = c_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (capture) begin
      k_d = '0;
      c_d = c_in;
    end else if (fetch && (k_q != K_LAST)) begin
      k_d = k_q + KW'(1);
    end
    if (vld_p0) begin
      c_d = c_byte;
      sum_d[{k_p0, 3'b000} +: 8] = s_byte;
      if (last_p0) begin
        cout_d = c_byte;
        ovf_d  = ovf_byte;
      end
    end
  end

  // Control and result registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      vld_p0  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      vld_p0  <= fetch;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand capture and p0 byte-select registers (data only, no reset).
  always_ff @(posedge clk) begin
    if (capture) begin
      a_q <= a;
      b_q <= b_in;
    end
    if (fetch) begin
      a_p0 <= a_q[{k_q, 3'b000} +: 8];
      b_p0 <= b_q[{k_q, 3'b000} +: 8];
      k_p0 <= k_q;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Testbench for byte_serial_adder with NBYTES=4: directed vector table,
// hand-written backpressure / reset sequences, and random operands checked
// against an arithmetic reference model.

module tb_byte_serial_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;
`ifdef BSA_SUB_EN
  logic        op_sub;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  byte_serial_adder #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BSA_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic mc, input logic ms,
                                output logic [31:0] s, output logic c, output logic o);
    longint sa, sb, r;
    longint unsigned ua, ub, u;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    if (ms) begin
      r = sa - sb;
      s = ma - mb;
      c = (ua >= ub);
    end else begin
      r = sa + sb + longint'(mc);
      u = ua + ub + {63'd0, mc};
      s = u[31:0];
      c = u[32];
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Present one operand pair, wait for the result, then accept it.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic ts, output logic [31:0] rs, output logic rc,
                        output logic ro, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
`ifdef BSA_SUB_EN
    op_sub = ts;
`else
    if (ts) $display("note: subtract requested but not built");
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rs = sum; rc = cout; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic ts, input logic [31:0] es,
                          input logic ec, input logic eo);
    logic [31:0] rs;
    logic rc, ro;
    int lat;
    run_op(ta, tb, tc, ts, rs, rc, ro, lat);
    chk({nm, ".sum"},  {32'd0, rs}, {32'd0, es});
    chk({nm, ".cout"}, {63'd0, rc}, {63'd0, ec});
    chk({nm, ".ovf"},  {63'd0, ro}, {63'd0, eo});
    chk({nm, ".lat"},  64'(lat), 64'd5);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] ra, rb, es, held;
    logic rc, rs_b, ec, eo;
    int lat;

    vecs.push_back('{"byte_carry",  32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0});
    vecs.push_back('{"wrap_b1",     32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"wrap_cin",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"sovf_pos",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{"sovf_neg",    32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{"plain",       32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0});
`ifdef BSA_SUB_EN
    vecs.push_back('{"sub_borrow",  32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
    op_sub = 1'b0;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.sum",       {32'd0, sum},       64'd0);
    chk("rst.cout",      {63'd0, cout},      64'd0);
    chk("rst.ovf",       {63'd0, ovf},       64'd0);

    // Reset and in_valid together: reset wins, nothing captured.
    rst = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstvld.in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    chk("rstvld.in_ready2",  {63'd0, in_ready},  64'd1);
    chk("rstvld.out_valid",  {63'd0, out_valid}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++)
      check_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
               vecs[i].es, vecs[i].ec, vecs[i].eo);

    // Backpressure: hold result in DONE while in_valid pushes other operands.
    a = 32'h000000FF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.lat", 64'(lat), 64'd5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.sum%0d", i),      {32'd0, sum},       64'h100);
      chk($sformatf("bp.cout%0d", i),     {63'd0, cout},      64'd0);
      chk($sformatf("bp.in_ready%0d", i), {63'd0, in_ready},  64'd0);
      chk($sformatf("bp.valid%0d", i),    {63'd0, out_valid}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.in_ready_after", {63'd0, in_ready},  64'd1);
    chk("bp.valid_after",    {63'd0, out_valid}, 64'd0);
    chk("bp.no_capture",     {32'd0, sum},       64'h100);
    check_op("bp.second", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

    // Mid-operation reset during byte k=2.
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst.sum",       {32'd0, sum},       64'd0);
    chk("midrst.cout",      {63'd0, cout},      64'd0);
    check_op("midrst.fresh", 32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80000000 ^ {24'd0, 8'($urandom)};
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'h7FFFFFFF : $urandom;
      rc = 1'($urandom);
`ifdef BSA_SUB_EN
      rs_b = 1'($urandom);
`else
      rs_b = 1'b0;
`endif
      model(ra, rb, rc, rs_b, es, ec, eo);
      check_op($sformatf("rnd%0d", i), ra, rb, rc, rs_b, es, ec, eo);
    end

    held = sum;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
